// File: rtl/seq_reduce_modp_if.sv
// rtl/seq_reduce_modp_if.sv - operand/result handshake bundle for seq_reduce_modp
//
// Purpose: groups the input-product and output-residue handshakes of the
// modular reducer so the producer and consumer can be wired as one port.
//
// Signals:
//   in_data   2N  product to reduce (producer -> reducer)
//   in_valid  1   in_data is valid (producer -> reducer)
//   in_ready  1   reducer can accept (reducer -> producer)
//   out_data  N   canonical residue (reducer -> consumer)
//   out_valid 1   out_data is valid (reducer -> consumer)
//   out_ready 1   consumer accepts out_data (consumer -> reducer)
//   fold_cnt  2   folds taken for the current/last operand (debug)
//
// Modports: slave = reducer side, master = producer/consumer side.

interface seq_reduce_modp_if #(
  parameter int N = 255
);
  logic [2*N-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     fold_cnt;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output fold_cnt
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  fold_cnt
  );
endinterface

// File: rtl/seq_reduce_modp.sv
// rtl/seq_reduce_modp.sv - sequential reduction of a 2N-bit product modulo p = 2^N - C
//
// Purpose: accepts a double-width product, repeatedly folds the high half
// back into the low half using 2^N == C (mod p) until the high half is zero,
// then applies one conditional subtract of p to return a residue in [0, p-1].
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  seq_reduce_modp_if.slave: in_data/in_valid/in_ready product input,
//        out_data/out_valid/out_ready residue output, fold_cnt debug count

module seq_reduce_modp #(
  parameter int N = 255,
  parameter int C = 19
) (
  input  logic             clk,
  input  logic             rst,
  seq_reduce_modp_if.slave bus
);

  localparam logic [N-1:0]   P   = {N{1'b1}} - N'(C - 1);
  localparam logic [2*N-1:0] C_W = (2*N)'(C);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   out_data_q;
  logic           out_valid_q;
  logic [1:0]     fold_cnt_q;

  logic [N-1:0]   hi;
  logic [N-1:0]   lo;
  logic [2*N-1:0] acc_d;
  logic [N-1:0]   out_data_d;

  assign hi = acc_q[2*N-1:N];
  assign lo = acc_q[N-1:0];

  // Fold at full 2N width: with C < 2^(N/2) the sum lo + C*hi cannot
  // overflow acc, so nothing is lost to truncation.
  assign acc_d = {{N{1'b0}}, lo} + C_W * {{N{1'b0}}, hi};

  // Once hi is zero, lo < 2^N < 2p, so a single subtract is canonical.
  assign out_data_d = (lo >= P) ? (lo - P) : lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      fold_cnt_q  <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            acc_q      <= bus.in_data;
            fold_cnt_q <= 2'd0;
            state_q    <= FOLD;
          end
        end
        FOLD: begin
          if (hi != '0) begin
            acc_q      <= acc_d;
            fold_cnt_q <= fold_cnt_q + 2'd1;
          end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fold_cnt  = fold_cnt_q;

endmodule

// File: tb/tb_seq_reduce_modp.sv
// tb/tb_seq_reduce_modp.sv - directed and random checks for seq_reduce_modp

module tb_seq_reduce_modp;

  localparam int N = 255;
  localparam logic [N-1:0] P = {N{1'b1}} - N'(18);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  seq_reduce_modp_if #(.N(N)) bus ();

  seq_reduce_modp #(.N(N), .C(19)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Binary long division remainder, bit by bit from the MSB.
  function automatic logic [N-1:0] ref_mod(input logic [2*N-1:0] x);
    logic [N:0] r;
    r = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      r = {r[N-1:0], x[i]};
      if (r >= {1'b0, P}) r = r - {1'b0, P};
    end
    return r[N-1:0];
  endfunction

  // Called #1 after an edge. Presents x, waits for acceptance, then counts
  // edges from the accept edge until out_valid rises.
  task automatic run_op(input logic [2*N-1:0] x, output logic [N-1:0] r,
                        output logic [1:0] fc, output int lat, output bit to);
    int w;
    to = 1'b0; lat = 0; r = '0; fc = 2'd0; w = 0;
    bus.in_data  = x;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      to = 1'b1;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~x;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.out_valid && lat < 8);
    if (!bus.out_valid) to = 1'b1;
    r  = bus.out_data;
    fc = bus.fold_cnt;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.fold_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_fold_cnt: got %0d want 0", bus.fold_cnt); end
    vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
  endtask

  task automatic test_zero();
    logic [N-1:0] r; logic [1:0] fc; int lat; bit to;
    run_op('0, r, fc, lat, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL zero_timeout: got %b want 0", to); end
    vectors++; if (r !== '0) begin miscompares++; $display("FAIL zero_data: got %h want 0", r); end
    vectors++; if (fc !== 2'd0) begin miscompares++; $display("FAIL zero_fold_cnt: got %0d want 0", fc); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL zero_latency: got %0d want 1", lat); end
    handshake();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_release_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL zero_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_fold_one();
    logic [2*N-1:0] x; logic [N-1:0] r; logic [1:0] fc; int lat; bit to;
    x = '0; x[N] = 1'b1;
    run_op(x, r, fc, lat, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL pow_timeout: got %b want 0", to); end
    vectors++; if (r !== N'(19)) begin miscompares++; $display("FAIL pow_data: got %h want 13", r); end
    vectors++; if (fc !== 2'd1) begin miscompares++; $display("FAIL pow_fold_cnt: got %0d want 1", fc); end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL pow_latency: got %0d want 2", lat); end
    handshake();
    x = {{N{1'b0}}, P};
    run_op(x, r, fc, lat, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL p_timeout: got %b want 0", to); end
    vectors++; if (r !== '0) begin miscompares++; $display("FAIL p_data: got %h want 0", r); end
    vectors++; if (fc !== 2'd0) begin miscompares++; $display("FAIL p_fold_cnt: got %0d want 0", fc); end
    handshake();
  endtask

  task automatic test_subtract();
    logic [2*N-1:0] x; logic [N-1:0] r; logic [1:0] fc; int lat; bit to;
    x = '0; x[N-1:0] = {N{1'b1}};
    run_op(x, r, fc, lat, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL sub_timeout: got %b want 0", to); end
    vectors++; if (r !== N'(18)) begin miscompares++; $display("FAIL sub_data: got %h want 12", r); end
    vectors++; if (fc !== 2'd0) begin miscompares++; $display("FAIL sub_fold_cnt: got %0d want 0", fc); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL sub_latency: got %0d want 1", lat); end
    handshake();
  endtask

  task automatic test_square_and_max();
    logic [2*N-1:0] pm1; logic [2*N-1:0] x; logic [N-1:0] r; logic [1:0] fc; int lat; bit to;
    pm1 = {{N{1'b0}}, P - N'(1)};
    x = pm1 * pm1;
    run_op(x, r, fc, lat, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL sq_timeout: got %b want 0", to); end
    vectors++; if (r !== N'(1)) begin miscompares++; $display("FAIL sq_data: got %h want 1", r); end
    vectors++; if (lat != int'(fc) + 1) begin miscompares++; $display("FAIL sq_latency: got %0d want %0d", lat, int'(fc) + 1); end
    handshake();
    // 2^510 - 1 == 19^2 - 1 = 360; folds: 20*(2^255-1), then 2^255+341, then 360
    x = {(2*N){1'b1}};
    run_op(x, r, fc, lat, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL max_timeout: got %b want 0", to); end
    vectors++; if (r !== N'(360)) begin miscompares++; $display("FAIL max_data: got %h want 168", r); end
    vectors++; if (r !== ref_mod(x)) begin miscompares++; $display("FAIL max_model: got %h want %h", r, ref_mod(x)); end
    vectors++; if (fc !== 2'd3) begin miscompares++; $display("FAIL max_fold_cnt: got %0d want 3", fc); end
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL max_latency: got %0d want 4", lat); end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [2*N-1:0] x; logic [N-1:0] r; logic [1:0] fc; int lat; bit to;
    x = '0; x[N] = 1'b1;
    run_op(x, r, fc, lat, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL bp_timeout: got %b want 0", to); end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {(2*N){1'b1}};
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_%0d: got %b want 1", i, bus.out_valid); end
      vectors++; if (bus.out_data !== N'(19)) begin miscompares++; $display("FAIL bp_data_%0d: got %h want 13", i, bus.out_data); end
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, bus.in_ready); end
      vectors++; if (bus.fold_cnt !== 2'd1) begin miscompares++; $display("FAIL bp_fold_cnt_%0d: got %0d want 1", i, bus.fold_cnt); end
    end
    bus.in_valid = 1'b0;
    handshake();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ignored_input: in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_idle_out_ready();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_ready_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_fold();
    bit seen;
    bus.in_data  = {(2*N){1'b1}};
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rstfold_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rstfold_in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.fold_cnt !== 2'd0) begin miscompares++; $display("FAIL rstfold_fold_cnt: got %0d want 0", bus.fold_cnt); end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rstfold_no_result: got %b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] x; logic [N-1:0] r; logic [N-1:0] exp_r; logic [1:0] fc; int lat; bit to;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x = '0;
      for (int w = 0; w < 16; w++) x = {x[2*N-33:0], 32'($urandom)};
      case (i % 4)
        0: x[2*N-1:N] = '0;
        1: x[2*N-1:N+8] = {(N-8){1'b1}};
        default: ;
      endcase
      exp_r = ref_mod(x);
      run_op(x, r, fc, lat, to);
      vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL rnd_timeout_%0d: got %b want 0", i, to); end
      vectors++; if (r !== exp_r) begin miscompares++; $display("FAIL rnd_data_%0d: got %h want %h", i, r, exp_r); end
      vectors++; if (lat != int'(fc) + 1 || lat > 4) begin miscompares++; $display("FAIL rnd_latency_%0d: got %0d want %0d (<=4)", i, lat, int'(fc) + 1); end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rnd_drain_ready: got %b want 1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_fold_one();
    test_subtract();
    test_square_and_max();
    test_backpressure();
    test_idle_out_ready();
    test_reset_mid_fold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
